// File: rtl/window_stream_ctrl_pkg.sv
// Shared definitions for the sliding-window stream controller.
//  - default sample width and window length
//  - controller state encodings (plain localparams so legacy code can
//    compare against them without an enum type)
//  - clog2 helper for sizing counters from parameters
package window_stream_ctrl_pkg;

    localparam int DEF_DATA_W   = 12;
    localparam int DEF_BUF_SIZE = 5;

    localparam logic [1:0] ST_CLR   = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Smallest r with 2**r >= v.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/window_stream_ctrl.sv
// window_stream_ctrl
//  Sequencer for a 1-D sliding-window shift buffer (FIR tap delay line).
//  Takes a valid/ready sample stream split into lines (s_last marks the final
//  sample), drives the buffer's clear/enable/shift/data pins and presents each
//  complete window to the MAC stage with valid/ready. After the last sample of
//  a line it shifts in BufferSize-1 zeros so a line of L samples gives exactly
//  L windows, the final one flagged with m_last.
//
//  Ports
//   clk, rst               clock; asynchronous active-low reset
//   s_valid/s_ready        input sample handshake
//   s_data, s_last         sample and end-of-line qualifier
//   buf_clr                zero all taps (buffer's sync reset pin)
//   buf_en, buf_shift      shift strobe to the buffer
//   buf_din                value shifted into the buffer
//   m_valid/m_ready        window handshake to the MAC stage
//   m_last                 with m_valid: final window of the line
module window_stream_ctrl
    import window_stream_ctrl_pkg::*;
#(
    parameter int DataBitWidth = DEF_DATA_W,
    parameter int BufferSize   = DEF_BUF_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DataBitWidth-1:0] s_data,
    input  logic                    s_last,
    output logic                    buf_clr,
    output logic                    buf_en,
    output logic                    buf_shift,
    output logic [DataBitWidth-1:0] buf_din,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last
);

    localparam int CW = clog2(BufferSize + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BufferSize);
    localparam logic [CW-1:0] PAD_LAST = CW'(BufferSize - 2);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] pad;
    logic          slot_free;
    logic          fire;

    // A shift overwrites the window at the buffer output, so it is only
    // allowed when that window is absent or being consumed this cycle.
    assign slot_free = !m_valid || m_ready;

    always_comb begin
        s_ready = 1'b0;
        fire    = 1'b0;
        buf_din = '0;
        case (state)
            ST_LOAD: begin
                s_ready = slot_free;
                fire    = s_valid && slot_free;
                buf_din = s_data;
            end
            ST_FLUSH: begin
                // m_last set means the final window is out; stop padding
                // until it is accepted.
                fire    = slot_free && !m_last;
                buf_din = '0;
            end
            default: begin
                s_ready = 1'b0;
                fire    = 1'b0;
            end
        endcase
    end

    assign buf_clr   = (state == ST_CLR);
    assign buf_en    = fire;
    assign buf_shift = fire;

    // Shifts since clear, saturating once the window is full.
    assign cnt_nxt = (fire && (cnt != CNT_FULL)) ? cnt + 1'b1 : cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_CLR;
            cnt     <= '0;
            pad     <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            if (fire)
                m_valid <= (cnt_nxt >= CNT_FULL);
            else if (m_ready)
                m_valid <= 1'b0;

            cnt <= (state == ST_CLR) ? '0 : cnt_nxt;

            case (state)
                ST_CLR: begin
                    state  <= ST_LOAD;
                    pad    <= '0;
                    m_last <= 1'b0;
                end
                ST_LOAD: begin
                    if (fire && s_last) begin
                        state <= ST_FLUSH;
                        pad   <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (fire) begin
                        pad <= pad + 1'b1;
                        if (pad == PAD_LAST)
                            m_last <= 1'b1;
                    end else if (m_last && m_valid && m_ready) begin
                        state  <= ST_CLR;
                        m_last <= 1'b0;
                    end
                end
                default: state <= ST_CLR;
            endcase
        end
    end

endmodule

// File: tb/tb_window_stream_ctrl.sv
// Bench for window_stream_ctrl (BufferSize=5, DataBitWidth=12).
// A model of the external shift buffer is driven from the DUT's buffer pins;
// the expected windows of each line are computed directly from the samples
// (window k = samples k..k+4, zero beyond the end of line).
module tb_window_stream_ctrl;

    localparam int DW = 12;
    localparam int BS = 5;

    typedef logic [0:BS-1][DW-1:0] win_t;
    typedef struct {
        win_t w;
        bit   last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          buf_clr;
    logic          buf_en;
    logic          buf_shift;
    logic [DW-1:0] buf_din;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    win_t win = '0;      // buffer model: [0] oldest tap
    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_win  = 0;
    int   n_last = 0;

    window_stream_ctrl #(.DataBitWidth(DW), .BufferSize(BS)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .buf_clr(buf_clr), .buf_en(buf_en), .buf_shift(buf_shift), .buf_din(buf_din),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic win_t mkwin(input int a, input int b, input int c, input int d, input int e);
        win_t w;
        w[0] = DW'(a); w[1] = DW'(b); w[2] = DW'(c); w[3] = DW'(d); w[4] = DW'(e);
        return w;
    endfunction

    task automatic push_line(input int xs[$]);
        int L;
        exp_t e;
        L = xs.size();
        for (int k = 0; k < L; k++) begin
            for (int j = 0; j < BS; j++)
                e.w[j] = (k + j < L) ? DW'(xs[k + j]) : '0;
            e.last = (k == L - 1);
            exp_q.push_back(e);
        end
    endtask

    // Compare process: checks every handshake against the expected queue,
    // plus stall/hold rules, then advances the buffer model.
    initial begin
        bit   ph;
        bit   pl;
        win_t pw;
        exp_t e;
        ph = 0; pl = 0; pw = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ph = 0; pl = 0;
            end else begin
                if (ph) begin
                    chk("hold_valid", 64'(m_valid), 64'(1));
                    chk("hold_window", 64'(win), 64'(pw));
                end
                if (m_valid && !m_ready)
                    chk("stall_no_shift", 64'({s_ready, buf_en}), 64'(0));
                if (pl)
                    chk("clr_after_last", 64'(buf_clr), 64'(1));
                if (m_valid && m_ready) begin
                    n_win++;
                    if (m_last) n_last++;
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL extra_window: got %0h expected none", win);
                    end else begin
                        e = exp_q.pop_front();
                        chk("window", 64'(win), 64'(e.w));
                        chk("last", 64'(m_last), 64'(e.last));
                    end
                end
                ph = m_valid && !m_ready;
                pw = win;
                pl = m_valid && m_ready && m_last;
            end
            if (buf_clr)
                win <= '0;
            else if (buf_en && buf_shift)
                win <= {win[1:BS-1], buf_din};
        end
    end

    // Stream one line. Expected windows must already be queued.
    task automatic run_line(input int xs[$], input int sv_pct, input int mr_pct,
                            input int stall_at, input bit abort, input bit first_chk);
        int  L, idx, cyc, fires, w0;
        bit  pend_first, stall;
        L = xs.size(); idx = 0; cyc = 0; fires = 0; w0 = n_win; pend_first = 0;
        forever begin
            @(posedge clk); #1;
            if (abort && idx == L) break;
            if (!abort && idx == L && exp_q.size() == 0) break;
            if (cyc > 3000) begin
                chk("line_timeout", 64'(idx), 64'(L));
                break;
            end
            stall   = (cyc >= stall_at) && (cyc < stall_at + 4);
            s_valid = (idx < L) && (stall || ($urandom_range(99) < sv_pct));
            s_data  = (idx < L) ? DW'(xs[idx]) : '0;
            s_last  = (idx == L - 1);
            m_ready = !stall && ($urandom_range(99) < mr_pct);
            @(negedge clk);
            if (pend_first) begin
                chk("first_win_valid", 64'(m_valid), 64'(1));
                chk("first_win_data", 64'(win), 64'(mkwin(1, 2, 3, 4, 5)));
                pend_first = 0;
            end
            if (stall && cyc > stall_at)
                chk("stall_valid_held", 64'(m_valid), 64'(1));
            if (s_valid && s_ready) begin
                idx++; fires++;
                if (first_chk && fires == BS) pend_first = 1;
            end
            cyc++;
        end
        s_valid = 0; s_last = 0;
        if (!abort)
            chk("window_count", 64'(n_win - w0), 64'(L));
    endtask

    initial begin
        int q[$];
        int lasts0;
        rst = 0; s_valid = 0; s_data = '0; s_last = 0; m_ready = 0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_buf_clr", 64'(buf_clr), 64'(1));
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk("clr_pulse", 64'(buf_clr), 64'(1));
        chk("clr_s_ready", 64'(s_ready), 64'(0));
        chk("clr_m_valid", 64'(m_valid), 64'(0));
        @(negedge clk);
        chk("load_buf_clr", 64'(buf_clr), 64'(0));
        chk("load_s_ready", 64'(s_ready), 64'(1));

        // Line 1..8, full throughput
        q = {1, 2, 3, 4, 5, 6, 7, 8};
        push_line(q);
        chk("model_w0", 64'(exp_q[0].w), 64'(mkwin(1, 2, 3, 4, 5)));
        chk("model_w7", 64'(exp_q[7].w), 64'(mkwin(8, 0, 0, 0, 0)));
        chk("model_w7_last", 64'(exp_q[7].last), 64'(1));
        run_line(q, 100, 100, -100, 0, 1);

        // Short line 7,9
        q = {7, 9};
        push_line(q);
        chk("model_short_n", 64'(exp_q.size()), 64'(2));
        chk("model_short_w0", 64'(exp_q[0].w), 64'(mkwin(7, 9, 0, 0, 0)));
        chk("model_short_w1", 64'(exp_q[1].w), 64'(mkwin(9, 0, 0, 0, 0)));
        run_line(q, 100, 100, -100, 0, 0);

        // Single-sample line
        q = {42};
        push_line(q);
        run_line(q, 100, 100, -100, 0, 0);

        // m_ready low for 4 clk mid-line
        q = {10, 11, 12, 13, 14, 15, 16, 17};
        push_line(q);
        run_line(q, 100, 100, 7, 0, 0);

        // 100-sample line with random gaps on both sides
        q.delete();
        for (int i = 0; i < 100; i++) q.push_back(int'($urandom_range(4095)));
        push_line(q);
        run_line(q, 70, 60, -100, 0, 0);

        // Reset during FLUSH
        q = {1, 2, 3, 4, 5, 6};
        push_line(q);
        lasts0 = n_last;
        run_line(q, 100, 100, -100, 1, 0);
        rst = 0;
        #1;
        chk("async_m_valid", 64'(m_valid), 64'(0));
        chk("async_m_last", 64'(m_last), 64'(0));
        chk("async_buf_clr", 64'(buf_clr), 64'(1));
        chk("abort_no_last", 64'(n_last - lasts0), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1;

        // Clean line after the aborted one
        q = {3, 5, 7};
        push_line(q);
        run_line(q, 80, 70, -100, 0, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
